regfile_writeback: RTL and testbench

- Write-back queue that is the writer side of the 8x8-bit register file (R0 hardwired to zero).
- Collects results from two producers: the ALU, and memory load responses.
- Buffers the results in order and drains one write per cycle into the register file's write port, only when mem_ready (the register-file enable) is high.
- Provides read-address hit detection and forwarding so the decode stage can bypass values that are still pending.

---
 rtl/regfile_writeback.sv | 163 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Write-back queue feeding the single write port of the 8x8-bit register
// file (R0 hardwired to zero). Results from the load unit and the ALU are
// buffered in arrival order in a small circular buffer. The buffer drains one
// entry per cycle whenever the register file is enabled (mem_ready). Pending
// entries can be forwarded to the decode stage.
//
// Optional feature (compile-time macro REGFILE_WB_FWD_EN):
//   defined   : fwdN_hit / fwdN_data report the youngest pending write that
//               targets rdN_addr.
//   undefined : all forwarding outputs are tied to 0 and no comparators exist.
//
// Ports:
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   mem_ready                     register-file enable; the queue drains only when 1
//   ld_valid/ld_addr/ld_data      load result in;  ld_ready  = accepted this cycle
//   alu_valid/alu_addr/alu_data   ALU result in;   alu_ready = accepted this cycle
//   rf_write_en/rf_addr_wr/rf_data_wr   register-file write port
//   rd1_addr, rd2_addr            decode read addresses
//   fwd1_hit/fwd1_data, fwd2_hit/fwd2_data   forwarding results
//   count, full                   occupancy and full flag
// ---------------------------------------------------------------------------
module regfile_writeback #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_ready,
   input  logic                     ld_valid,
   input  logic [AW-1:0]            ld_addr,
   input  logic [DW-1:0]            ld_data,
   output logic                     ld_ready,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_addr,
   input  logic [DW-1:0]            alu_data,
   output logic                     alu_ready,
   output logic                     rf_write_en,
   output logic [AW-1:0]            rf_addr_wr,
   output logic [DW-1:0]            rf_data_wr,
   input  logic [AW-1:0]            rd1_addr,
   input  logic [AW-1:0]            rd2_addr,
   output logic                     fwd1_hit,
   output logic [DW-1:0]            fwd1_data,
   output logic                     fwd2_hit,
   output logic [DW-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   cnt;

   logic            ld_push;
   logic            alu_push;
   logic [1:0]      n_push;
   logic            pop;
   logic [PW-1:0]   alu_slot;
   logic            not_empty;

   // Acceptance looks only at the registered occupancy, so a same-cycle drain
   // never frees a slot early. A pending load reserves one slot ahead of the
   // ALU result because the load is the older of the two.
   assign ld_ready  = (cnt <= CW'(DEPTH - 1));
   assign alu_ready = ld_valid ? (cnt <= CW'(DEPTH - 2)) : (cnt <= CW'(DEPTH - 1));

   // Writes to R0 are handshaken but dropped: they never occupy an entry.
   assign ld_push  = ld_valid  & ld_ready  & (ld_addr  != '0);
   assign alu_push = alu_valid & alu_ready & (alu_addr != '0);
   assign n_push   = {1'b0, ld_push} + {1'b0, alu_push};

   // The ALU result lands behind the load when both are enqueued together.
   assign alu_slot = tail + PW'(ld_push);

   assign not_empty = (cnt != '0);

   // A reset cycle must not commit anything to the register file, even though
   // the flush itself only takes effect at the edge.
   assign rf_write_en = mem_ready & not_empty & ~rst;
   assign pop         = rf_write_en;
   assign rf_addr_wr  = not_empty ? mem[head].addr : '0;
   assign rf_data_wr  = not_empty ? mem[head].data : '0;

   assign count = cnt;
   assign full  = (cnt == CW'(DEPTH));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (pop) begin
            head <= head + PW'(1);
         end
         tail <= tail + PW'(n_push);
         cnt  <= cnt + CW'(n_push) - CW'(pop);
      end
   end

   // NOTE: the entry storage has no reset; validity is defined purely by the
   // head/count window, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (ld_push) begin
         mem[tail] <= '{addr: ld_addr, data: ld_data};
      end
      if (alu_push) begin
         mem[alu_slot] <= '{addr: alu_addr, data: alu_data};
      end
   end

`ifdef REGFILE_WB_FWD_EN
   // Walk the live window from oldest to youngest; a later match overrides an
   // earlier one, leaving the youngest pending value. The draining head entry
   // is still inside the window, so it stays visible this cycle.
   // NOTE: every output is given a default before the loop so no latch is
   // inferred when no entry matches.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < cnt) begin
            if ((rd1_addr != '0) && (mem[head + PW'(k)].addr == rd1_addr)) begin
               fwd1_hit  = 1'b1;
               fwd1_data = mem[head + PW'(k)].data;
            end
            if ((rd2_addr != '0) && (mem[head + PW'(k)].addr == rd2_addr)) begin
               fwd2_hit  = 1'b1;
               fwd2_data = mem[head + PW'(k)].data;
            end
         end
      end
   end
`else
   // Forwarding disabled: outputs are constant and the read addresses are
   // intentionally left without a load.
   logic unused_rd_addr;
   assign unused_rd_addr = ^{rd1_addr, rd2_addr};

   assign fwd1_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_hit  = 1'b0;
   assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//
// Self-checking bench for regfile_writeback. A table of directed per-cycle
// vectors covers the named corner cases; a randomized phase then compares
// the DUT against a queue-based reference model. Forwarding expectations are
// forced to 0 when REGFILE_WB_FWD_EN is not defined.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;

   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_ready;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          alu_valid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          rf_write_en;
   logic [AW-1:0] rf_addr_wr;
   logic [DW-1:0] rf_data_wr;
   logic [AW-1:0] rd1_addr;
   logic [AW-1:0] rd2_addr;
   logic          fwd1_hit;
   logic [DW-1:0] fwd1_data;
   logic          fwd2_hit;
   logic [DW-1:0] fwd2_data;
   logic [2:0]    count;
   logic          full;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   regfile_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_ready   (mem_ready),
      .ld_valid    (ld_valid),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .alu_valid   (alu_valid),
      .alu_addr    (alu_addr),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .rf_write_en (rf_write_en),
      .rf_addr_wr  (rf_addr_wr),
      .rf_data_wr  (rf_data_wr),
      .rd1_addr    (rd1_addr),
      .rd2_addr    (rd2_addr),
      .fwd1_hit    (fwd1_hit),
      .fwd1_data   (fwd1_data),
      .fwd2_hit    (fwd2_hit),
      .fwd2_data   (fwd2_data),
      .count       (count),
      .full        (full)
   );

   typedef struct {
      logic          rst, mr, lv;
      logic [AW-1:0] la;
      logic [DW-1:0] ldd;
      logic          av;
      logic [AW-1:0] aa;
      logic [DW-1:0] ad;
      logic [AW-1:0] r1, r2;
   } in_t;

   typedef struct {
      logic          lr, ar, we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [2:0]    cnt;
      logic          f1h;
      logic [DW-1:0] f1d;
      logic          f2h;
      logic [DW-1:0] f2d;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];

   function automatic vec_t v(input int rst_i, mr, lv, la, ldd, av, aa, ad, r1, r2,
                              input int lr, ar, we, wa, wd, cnt, f1h, f1d, f2h, f2d);
      vec_t r;
      r.i.rst = 1'(rst_i); r.i.mr = 1'(mr);  r.i.lv = 1'(lv);
      r.i.la  = 3'(la);    r.i.ldd = 8'(ldd); r.i.av = 1'(av);
      r.i.aa  = 3'(aa);    r.i.ad = 8'(ad);  r.i.r1 = 3'(r1); r.i.r2 = 3'(r2);
      r.o.lr  = 1'(lr);    r.o.ar = 1'(ar);  r.o.we = 1'(we);
      r.o.wa  = 3'(wa);    r.o.wd = 8'(wd);  r.o.cnt = 3'(cnt);
      r.o.f1h = 1'(f1h);   r.o.f1d = 8'(f1d);
      r.o.f2h = 1'(f2h);   r.o.f2d = 8'(f2d);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t i);
      rst       = i.rst;
      mem_ready = i.mr;
      ld_valid  = i.lv;
      ld_addr   = i.la;
      ld_data   = i.ldd;
      alu_valid = i.av;
      alu_addr  = i.aa;
      alu_data  = i.ad;
      rd1_addr  = i.r1;
      rd2_addr  = i.r2;
   endtask

   task automatic compare(input string tag, input out_t e_in);
      out_t e;
      e = e_in;
`ifndef REGFILE_WB_FWD_EN
      e.f1h = 1'b0; e.f1d = '0; e.f2h = 1'b0; e.f2d = '0;
`endif
      check({tag, ".ld_ready"},  32'(ld_ready),    32'(e.lr));
      check({tag, ".alu_ready"}, 32'(alu_ready),   32'(e.ar));
      check({tag, ".wr_en"},     32'(rf_write_en), 32'(e.we));
      check({tag, ".wr_addr"},   32'(rf_addr_wr),  32'(e.wa));
      check({tag, ".wr_data"},   32'(rf_data_wr),  32'(e.wd));
      check({tag, ".count"},     32'(count),       32'(e.cnt));
      check({tag, ".full"},      32'(full),        32'(e.cnt == 3'(DEPTH)));
      check({tag, ".fwd1_hit"},  32'(fwd1_hit),    32'(e.f1h));
      check({tag, ".fwd1_data"}, 32'(fwd1_data),   32'(e.f1d));
      check({tag, ".fwd2_hit"},  32'(fwd2_hit),    32'(e.f2h));
      check({tag, ".fwd2_data"}, 32'(fwd2_data),   32'(e.f2d));
   endtask

   // Reference model: expected outputs for the current inputs, from the queue.
   function automatic out_t model_out(input in_t i);
      out_t e;
      int   n;
      n     = q.size();
      e.lr  = (n < DEPTH);
      e.ar  = i.lv ? (n < DEPTH - 1) : (n < DEPTH);
      e.we  = i.mr && (n > 0) && !i.rst;
      e.wa  = (n > 0) ? q[0].addr : '0;
      e.wd  = (n > 0) ? q[0].data : '0;
      e.cnt = 3'(n);
      e.f1h = 1'b0; e.f1d = '0; e.f2h = 1'b0; e.f2d = '0;
      for (int k = n - 1; k >= 0; k--) begin
         if (!e.f1h && i.r1 != 0 && q[k].addr == i.r1) begin e.f1h = 1'b1; e.f1d = q[k].data; end
         if (!e.f2h && i.r2 != 0 && q[k].addr == i.r2) begin e.f2h = 1'b1; e.f2d = q[k].data; end
      end
      return e;
   endfunction

   task automatic model_update(input in_t i, input out_t e);
      ent_t t;
      if (i.rst) begin
         q.delete();
      end else begin
         if (e.we) void'(q.pop_front());
         if (i.lv && e.lr && i.la != 0) begin t.addr = i.la; t.data = i.ldd; q.push_back(t); end
         if (i.av && e.ar && i.aa != 0) begin t.addr = i.aa; t.data = i.ad; q.push_back(t); end
      end
   endtask

   initial begin
      in_t  ri;
      out_t re;
      logic ld_hold, alu_hold;

      //               rst mr lv la ldd   av aa ad    r1 r2   lr ar we wa wd   cnt f1h f1d f2h f2d
      vecs.push_back(v(1, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      // Single ALU write, drained the next cycle and still forwardable while draining.
      vecs.push_back(v(0, 1, 0, 0, 0,    1, 3, 'h5A, 3, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    3, 0,   1, 1, 1, 3, 'h5A, 1, 1, 'h5A, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    3, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      // Fill to full with the register file disabled, then drain in order.
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 1, 'h11, 0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 2, 'h22, 0, 0,   1, 1, 0, 1, 'h11, 1, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 3, 'h33, 0, 0,   1, 1, 0, 1, 'h11, 2, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 4, 'h44, 0, 0,   1, 1, 0, 1, 'h11, 3, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    0, 0, 0,    2, 0,   0, 0, 0, 1, 'h11, 4, 1, 'h22, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   0, 0, 1, 1, 'h11, 4, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 2, 'h22, 3, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 3, 'h33, 2, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 4, 'h44, 1, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      // Same-cycle load + ALU: load first.
      vecs.push_back(v(0, 1, 1, 2, 'hAA, 1, 5, 'hBB, 0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    5, 2,   1, 1, 1, 2, 'hAA, 2, 1, 'hBB, 1, 'hAA));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 5, 'hBB, 1, 0, 0,    0, 0));
      // count=3 with both producers valid: only the load fits.
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 1, 1,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 2, 2,    0, 0,   1, 1, 0, 1, 1,    1, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 3, 3,    0, 0,   1, 1, 0, 1, 1,    2, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 1, 6, 'h66, 1, 7, 'h77, 6, 0,   1, 0, 0, 1, 1,    3, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 7, 'h77, 6, 1,   0, 0, 0, 1, 1,    4, 1, 'h66, 1, 1));
      vecs.push_back(v(0, 1, 0, 0, 0,    1, 7, 'h77, 0, 0,   0, 0, 1, 1, 1,    4, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    1, 7, 'h77, 0, 0,   1, 1, 1, 2, 2,    3, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 3, 3,    3, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 6, 'h66, 2, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 1, 7, 'h77, 1, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      // Writes to R0 are accepted but never queued or written.
      vecs.push_back(v(0, 1, 0, 0, 0,    1, 0, 'hFF, 0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 1, 0, 'hEE, 0, 0, 0,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      // Two pending writes to R6: forwarding returns the younger one.
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 6, 1,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 6, 2,    6, 0,   1, 1, 0, 6, 1,    1, 1, 1,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    0, 0, 0,    6, 0,   1, 1, 0, 6, 1,    2, 1, 2,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    6, 0,   1, 1, 1, 6, 1,    2, 1, 2,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    6, 0,   1, 1, 1, 6, 2,    1, 1, 2,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    6, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      // Reset with three pending writes and the register file enabled.
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 1, 'h0A, 0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 2, 'h0B, 0, 0,   1, 1, 0, 1, 'h0A, 1, 0, 0,    0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0,    1, 3, 'h0C, 0, 0,   1, 1, 0, 1, 'h0A, 2, 0, 0,    0, 0));
      vecs.push_back(v(1, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 1, 'h0A, 3, 0, 0,    0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0,    0, 0, 0,    0, 0,   1, 1, 0, 0, 0,    0, 0, 0,    0, 0));

      // Power-up reset.
      ri = vecs[0].i;
      drive(ri);
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[n]) begin
         drive(vecs[n].i);
         @(negedge clk);
         compare($sformatf("vec%0d", n), vecs[n].o);
         @(posedge clk);
         #1;
      end

      // Randomized phase: producers hold their result until it is accepted.
      q.delete();
      ri       = vecs[0].i;
      ri.rst   = 1'b0;
      ld_hold  = 1'b0;
      alu_hold = 1'b0;
      for (int c = 0; c < 600; c++) begin
         ri.rst = ($urandom_range(0, 39) == 0);
         ri.mr  = ($urandom_range(0, 3) != 0);
         if (!ld_hold) begin
            ri.lv  = $urandom_range(0, 1) != 0;
            ri.la  = 3'($urandom_range(0, 7));
            ri.ldd = 8'($urandom);
         end
         if (!alu_hold) begin
            ri.av = $urandom_range(0, 1) != 0;
            ri.aa = 3'($urandom_range(0, 7));
            ri.ad = 8'($urandom);
         end
         ri.r1 = 3'($urandom_range(0, 7));
         ri.r2 = 3'($urandom_range(0, 7));
         drive(ri);
         re = model_out(ri);
         @(negedge clk);
         compare($sformatf("rnd%0d", c), re);
         @(posedge clk);
         #1;
         model_update(ri, re);
         ld_hold  = ri.lv && !re.lr && !ri.rst;
         alu_hold = ri.av && !re.ar && !ri.rst;
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
